// File: rtl/vivo_stream_fifo.sv
// vivo_stream_fifo
//   Variable-in / variable-out element FIFO built on one flat circular buffer
//   of DEPTH elements. A push offers 1..IN_ELEMS_MAX elements and a pop takes
//   1..OUT_ELEMS_MAX elements. Because element slots are addressed
//   individually, DEPTH does not have to be a multiple of either lane count.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   flush           synchronous discard of all contents; blocks push and pop
//   in_valid/ready  push handshake; in_data lane 0 = oldest, in_num_elems = count offered
//   out_valid/ready pop handshake; out_data lane 0 = oldest
//   out_num_elems   elements presented this cycle (0 when !out_valid)
//   out_req_elems   elements requested by the consumer (clamped to OUT_ELEMS_MAX)
//   count           registered occupancy
//   almost_full     count >= AF_THRESH
//   almost_empty    count <= AE_THRESH
//   max_count       high-water mark of count since reset (survives flush)
module vivo_stream_fifo #(
   parameter int ELEM_WIDTH    = 8,
   parameter int DEPTH         = 64,
   parameter int IN_ELEMS_MAX  = 4,
   parameter int OUT_ELEMS_MAX = 4,
   parameter int PARTIAL_POP   = 0,
   parameter int AF_THRESH     = DEPTH - IN_ELEMS_MAX,
   parameter int AE_THRESH     = OUT_ELEMS_MAX
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  flush,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic [IN_ELEMS_MAX*ELEM_WIDTH-1:0]    in_data,
   input  logic [$clog2(IN_ELEMS_MAX+1)-1:0]     in_num_elems,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [OUT_ELEMS_MAX*ELEM_WIDTH-1:0]   out_data,
   output logic [$clog2(OUT_ELEMS_MAX+1)-1:0]    out_num_elems,
   input  logic [$clog2(OUT_ELEMS_MAX+1)-1:0]    out_req_elems,
   output logic [$clog2(DEPTH+1)-1:0]            count,
   output logic                                  almost_full,
   output logic                                  almost_empty,
   output logic [$clog2(DEPTH+1)-1:0]            max_count
);

   localparam int CW = $clog2(DEPTH+1);
   // One spare bit so count + pushed never wraps before the subtract.
   localparam int XW = CW + 1;
   localparam int OW = $clog2(OUT_ELEMS_MAX+1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef logic [ELEM_WIDTH-1:0] elem_t;

   elem_t                                    mem [DEPTH];
   logic [PW-1:0]                            rd_ptr, wr_ptr;
   logic [CW-1:0]                            count_q, max_q;

   logic [IN_ELEMS_MAX-1:0][ELEM_WIDTH-1:0]  in_lanes;
   logic [OUT_ELEMS_MAX-1:0][ELEM_WIDTH-1:0] out_lanes;
   logic [IN_ELEMS_MAX-1:0][PW-1:0]          wr_idx;
   logic [OUT_ELEMS_MAX-1:0][PW-1:0]         rd_idx;

   logic [XW-1:0] in_n, cnt_x, free_x, req_x, out_n_x, count_nx;
   logic [OW-1:0] req_eff;
   logic          cnt_ok, push, pop;

   // ptr + off modulo DEPTH. Both operands are < DEPTH (or off == DEPTH at
   // most), so a single conditional subtract is enough for any DEPTH.
   function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base,
                                              input logic [XW-1:0] off);
      logic [XW:0] sum;
      sum = (XW+1)'(base) + (XW+1)'(off);
      if (sum >= (XW+1)'(DEPTH))
         sum = sum - (XW+1)'(DEPTH);
      return sum[PW-1:0];
   endfunction

   assign in_lanes = in_data;
   assign out_data = out_lanes;
   assign count     = count_q;
   assign max_count = max_q;

   // ---------------- push side ----------------
   assign in_n   = XW'(in_num_elems);
   assign cnt_x  = XW'(count_q);
   assign free_x = XW'(DEPTH) - cnt_x;

   // Space released by a same-cycle pop is deliberately not credited, so
   // in_ready never depends on out_ready.
   assign in_ready = !flush && (in_n != '0) && (in_n <= XW'(IN_ELEMS_MAX)) &&
                     (in_n <= free_x);
   assign push     = in_valid && in_ready;

   // ---------------- pop side ----------------
   assign req_eff = (out_req_elems > OW'(OUT_ELEMS_MAX)) ? OW'(OUT_ELEMS_MAX)
                                                         : out_req_elems;
   assign req_x   = XW'(req_eff);
   assign cnt_ok  = (PARTIAL_POP != 0) ? (cnt_x != '0) : (cnt_x >= req_x);

   assign out_valid     = !flush && (req_x != '0) && cnt_ok;
   assign out_n_x       = !out_valid ? '0 : ((req_x < cnt_x) ? req_x : cnt_x);
   assign out_num_elems = OW'(out_n_x);
   assign pop           = out_valid && out_ready;

   // Per-lane slot addresses; lanes wrap independently mid-transfer.
   for (genvar j = 0; j < IN_ELEMS_MAX; j++) begin : g_wr
      assign wr_idx[j] = wrap_add(wr_ptr, XW'(j));
   end

   for (genvar i = 0; i < OUT_ELEMS_MAX; i++) begin : g_rd
      assign rd_idx[i]    = wrap_add(rd_ptr, XW'(i));
      assign out_lanes[i] = (XW'(i) < out_n_x) ? mem[rd_idx[i]] : '0;
   end

   // Storage is not reset; the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      for (int j = 0; j < IN_ELEMS_MAX; j++) begin
         if (push && (XW'(j) < in_n))
            mem[wr_idx[j]] <= in_lanes[j];
      end
   end

   assign count_nx = cnt_x + (push ? in_n : '0) - (pop ? out_n_x : '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
         max_q   <= '0;
      end else if (flush) begin
         // High-water mark survives flush on purpose.
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push)
            wr_ptr <= wrap_add(wr_ptr, in_n);
         if (pop)
            rd_ptr <= wrap_add(rd_ptr, out_n_x);
         count_q <= count_nx[CW-1:0];
         if (count_nx > XW'(max_q))
            max_q <= count_nx[CW-1:0];
      end
   end

   assign almost_full  = cnt_x >= XW'(AF_THRESH);
   assign almost_empty = cnt_x <= XW'(AE_THRESH);

endmodule

// File: tb/tb_vivo_stream_fifo.sv
// Bench for vivo_stream_fifo. Two instances: u0 (DEPTH 64, full-pop mode)
// and u1 (DEPTH 6, partial-pop mode). Expected pops are queued by the
// stimulus and checked by an independent monitor; status outputs are
// checked directly against hand-computed constants.
module tb_vivo_stream_fifo;

   logic              clk, rst_n;
   logic [1:0]        flush, in_valid, out_ready;
   logic [1:0][31:0]  in_data;
   logic [1:0][2:0]   in_num, out_req;
   logic [1:0]        in_ready, out_valid, af, ae;
   logic [1:0][31:0]  out_data;
   logic [1:0][2:0]   out_num;
   logic [1:0][6:0]   cnt, mx;
   logic [2:0]        b_cnt, b_mx;

   int n_tests, n_fail;
   logic [34:0] q0[$], q1[$];

   assign cnt[1] = {4'd0, b_cnt};
   assign mx[1]  = {4'd0, b_mx};

   vivo_stream_fifo #(.DEPTH(64)) u0 (
      .clk(clk), .rst_n(rst_n), .flush(flush[0]),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
      .in_num_elems(in_num[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .out_data(out_data[0]), .out_num_elems(out_num[0]), .out_req_elems(out_req[0]),
      .count(cnt[0]), .almost_full(af[0]), .almost_empty(ae[0]), .max_count(mx[0]));

   vivo_stream_fifo #(.DEPTH(6), .PARTIAL_POP(1)) u1 (
      .clk(clk), .rst_n(rst_n), .flush(flush[1]),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
      .in_num_elems(in_num[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .out_data(out_data[1]), .out_num_elems(out_num[1]), .out_req_elems(out_req[1]),
      .count(b_cnt), .almost_full(af[1]), .almost_empty(ae[1]), .max_count(b_mx));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic nx();
      @(posedge clk);
      #1;
   endtask

   task automatic ng();
      @(negedge clk);
   endtask

   task automatic idle();
      flush = '0; in_valid = '0; out_ready = '0;
      in_data = '0; in_num = '0; out_req = '0;
   endtask

   task automatic push(input int k, input logic [2:0] n, input logic [31:0] d);
      in_valid[k] = 1'b1;
      in_num[k]   = n;
      in_data[k]  = d;
   endtask

   task automatic exp_pop(input int k, input logic [2:0] n, input logic [31:0] d);
      if (k == 0) q0.push_back({n, d});
      else        q1.push_back({n, d});
   endtask

   // Monitor: every accepted pop must match the head of its scoreboard queue.
   always @(negedge clk) begin : mon
      logic [34:0] e;
      if (rst_n) begin
         for (int k = 0; k < 2; k++) begin
            if (out_valid[k] && out_ready[k]) begin
               if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL sb_unexpected_pop u%0d: got num %0d data %h expected none",
                           k, out_num[k], out_data[k]);
               end else begin
                  e = (k == 0) ? q0.pop_front() : q1.pop_front();
                  chk($sformatf("sb_num u%0d", k), 64'(out_num[k]), 64'(e[34:32]));
                  chk($sformatf("sb_data u%0d", k), 64'(out_data[k]), 64'(e[31:0]));
               end
            end
         end
      end
   end

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      idle();
      out_req[0] = 3'd2;

      // ---- reset state ----
      ng();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("rst_count u%0d", k), 64'(cnt[k]), 0);
         chk($sformatf("rst_max u%0d", k), 64'(mx[k]), 0);
         chk($sformatf("rst_out_valid u%0d", k), 64'(out_valid[k]), 0);
         chk($sformatf("rst_out_data u%0d", k), 64'(out_data[k]), 0);
         chk($sformatf("rst_ae u%0d", k), 64'(ae[k]), 1);
         chk($sformatf("rst_af u%0d", k), 64'(af[k]), 0);
      end
      nx();
      rst_n = 1'b1;
      idle();

      // ---- basic push 3, pop 2 then 1 (u0, full-pop mode) ----
      push(0, 3'd3, 32'h00C3B2A1);
      ng(); chk("t1_in_ready", 64'(in_ready[0]), 1); nx();
      in_valid[0] = 1'b0; out_req[0] = 3'd2;
      ng();
      chk("t1_count", 64'(cnt[0]), 3);
      chk("t1_out_valid", 64'(out_valid[0]), 1);
      chk("t1_out_num", 64'(out_num[0]), 2);
      chk("t1_out_data", 64'(out_data[0]), 64'h0000B2A1);
      nx();
      out_ready[0] = 1'b1; exp_pop(0, 3'd2, 32'h0000B2A1);
      ng(); nx();
      out_ready[0] = 1'b0;
      ng();
      chk("t1_count_after", 64'(cnt[0]), 1);
      chk("t1_short_no_valid", 64'(out_valid[0]), 0);
      chk("t1_max", 64'(mx[0]), 3);
      nx();
      out_req[0] = 3'd1; out_ready[0] = 1'b1; exp_pop(0, 3'd1, 32'h000000C3);
      ng(); nx();
      out_ready[0] = 1'b0; out_req[0] = 3'd0;
      ng(); chk("t1_empty", 64'(cnt[0]), 0); chk("t1_ae", 64'(ae[0]), 1); nx();

      // ---- simultaneous push/pop then flush (u0) ----
      push(0, 3'd4, 32'h13121110);
      ng(); nx();
      push(0, 3'd1, 32'h00000014);
      ng(); nx();
      push(0, 3'd2, 32'h00001615);
      out_req[0] = 3'd1; out_ready[0] = 1'b1; exp_pop(0, 3'd1, 32'h00000010);
      ng(); chk("t5_count5", 64'(cnt[0]), 5); chk("t5_in_ready", 64'(in_ready[0]), 1); nx();
      in_valid[0] = 1'b0; out_ready[0] = 1'b0; out_req[0] = 3'd0;
      ng(); chk("t5_count6", 64'(cnt[0]), 6); chk("t5_max6", 64'(mx[0]), 6); nx();
      flush[0] = 1'b1; push(0, 3'd1, 32'h000000FF);
      out_req[0] = 3'd4; out_ready[0] = 1'b1;
      ng();
      chk("t5_flush_in_ready", 64'(in_ready[0]), 0);
      chk("t5_flush_out_valid", 64'(out_valid[0]), 0);
      chk("t5_flush_out_num", 64'(out_num[0]), 0);
      nx();
      flush[0] = 1'b0; in_valid[0] = 1'b0; out_ready[0] = 1'b0; out_req[0] = 3'd1;
      ng();
      chk("t5_post_flush_count", 64'(cnt[0]), 0);
      chk("t5_post_flush_valid", 64'(out_valid[0]), 0);
      chk("t5_max_kept", 64'(mx[0]), 6);
      nx();
      out_req[0] = 3'd0;

      // ---- wrap-around (u1, DEPTH 6) ----
      push(1, 3'd4, 32'h23222120);
      ng(); nx();
      in_valid[1] = 1'b0; out_req[1] = 3'd4; out_ready[1] = 1'b1;
      exp_pop(1, 3'd4, 32'h23222120);
      ng(); nx();
      out_ready[1] = 1'b0; out_req[1] = 3'd0; push(1, 3'd4, 32'h27262524);
      ng(); chk("t2_empty_mid", 64'(cnt[1]), 0); chk("t2_in_ready", 64'(in_ready[1]), 1); nx();
      in_valid[1] = 1'b0; out_req[1] = 3'd4; out_ready[1] = 1'b1;
      exp_pop(1, 3'd4, 32'h27262524);
      ng(); chk("t2_count4", 64'(cnt[1]), 4); nx();
      out_ready[1] = 1'b0; out_req[1] = 3'd0;
      ng(); chk("t2_count0", 64'(cnt[1]), 0); nx();

      // ---- fill to full one element at a time (u1) ----
      for (int i = 0; i < 6; i++) begin
         push(1, 3'd1, 32'(8'h30 + i));
         ng(); chk($sformatf("t3_fill_ready%0d", i), 64'(in_ready[1]), 1); nx();
      end
      push(1, 3'd1, 32'h00000036);
      ng();
      chk("t3_full_count", 64'(cnt[1]), 6);
      chk("t3_full_af", 64'(af[1]), 1);
      chk("t3_full_in_ready", 64'(in_ready[1]), 0);
      nx();
      out_req[1] = 3'd1; out_ready[1] = 1'b1; exp_pop(1, 3'd1, 32'h00000030);
      ng(); chk("t3_pop_no_credit", 64'(in_ready[1]), 0); nx();
      in_valid[1] = 1'b0; out_ready[1] = 1'b0;
      ng(); chk("t3_count5", 64'(cnt[1]), 5); chk("t3_ready_next", 64'(in_ready[1]), 1); nx();
      out_req[1] = 3'd3; out_ready[1] = 1'b1; exp_pop(1, 3'd3, 32'h00333231);
      ng(); nx();

      // ---- partial pop: count 2, req 4 (u1) ----
      out_req[1] = 3'd4; out_ready[1] = 1'b1; exp_pop(1, 3'd2, 32'h00003534);
      ng();
      chk("t4_count2", 64'(cnt[1]), 2);
      chk("t4_out_num", 64'(out_num[1]), 2);
      chk("t4_upper_lanes", 64'(out_data[1][31:16]), 0);
      nx();
      out_ready[1] = 1'b0; out_req[1] = 3'd0;
      ng();
      chk("t4_count0", 64'(cnt[1]), 0);
      chk("t4_ae", 64'(ae[1]), 1);
      chk("t4_af", 64'(af[1]), 0);
      nx();

      // ---- asynchronous reset mid-cycle (count 10 on u0) ----
      push(0, 3'd4, 32'h43424140); ng(); nx();
      push(0, 3'd4, 32'h47464544); ng(); nx();
      push(0, 3'd2, 32'h00004948); ng(); nx();
      in_valid[0] = 1'b0; out_req[0] = 3'd1;
      ng();
      chk("t6_count10", 64'(cnt[0]), 10);
      chk("t6_valid_before", 64'(out_valid[0]), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_async_count", 64'(cnt[0]), 0);
      chk("t6_async_valid", 64'(out_valid[0]), 0);
      chk("t6_async_max", 64'(mx[0]), 0);
      chk("t6_async_max_u1", 64'(mx[1]), 0);
      chk("t6_async_ae", 64'(ae[0]), 1);
      nx();
      rst_n = 1'b1;
      ng();
      chk("t6_post_count", 64'(cnt[0]), 0);
      chk("t6_post_valid", 64'(out_valid[0]), 0);
      nx();
      idle();

      chk("sb_drained", 64'(q0.size() + q1.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
